// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader.
//   state_t           : loader FSM state encoding
//   DEFAULT_MAX_WORDS : default largest accepted program length in 32-bit words
//   HDR_WIDTH         : width of the stream header word count
package loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StHdrHi,
        StHdrLo,
        StCollect,
        StWrite,
        StDone,
        StError
    } state_t;

    localparam int unsigned DEFAULT_MAX_WORDS = 256;
    localparam int unsigned HDR_WIDTH         = 16;

endpackage

// File: rtl/word_assembler.sv
// Big-endian 8-to-32 assembler: bytes shift in from the low end, so the first
// byte of a word ends up in bits [31:24].
//   clk      : clock
//   reset    : synchronous active-low reset
//   clear    : synchronous clear of the assembly register and byte counter
//   shift    : accept byteData this cycle
//   byteData : incoming stream byte
//   word     : assembly register contents
//   wordFull : the byte being shifted in now is the 4th of its word
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic [7:0]  byteData,
    output logic [31:0] word,
    output logic        wordFull
);

    logic [31:0] word_q;
    logic [1:0]  count_q;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            word_q  <= 32'h0;
            count_q <= 2'd0;
        end else if (shift) begin
            word_q  <= {word_q[23:0], byteData};
            // Wraps back to 0 after the 4th byte, ready for the next word.
            count_q <= count_q + 2'd1;
        end
    end

    assign word     = word_q;
    assign wordFull = shift && (count_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a program from a byte stream into instruction memory while holding the
// processor in reset. Stream: 16-bit word count N (high byte first), then N
// big-endian 32-bit words.
//   clk, reset          : clock, synchronous active-low reset
//   start               : begin/restart a load (honoured in idle, done, error)
//   byteValid, byteData : byte stream source; byteReady is the handshake back
//   memWrite            : one-cycle write strobe, with memAddress/memWriteData
//   cpuReset            : processor hold-in-reset, released only after success
//   busy, done, error   : load status
module imem_loader
    import loader_pkg::*;
#(
    parameter int unsigned MAX_WORDS    = DEFAULT_MAX_WORDS,
    parameter logic [31:0] BASE_ADDRESS = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic        byteReady,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        cpuReset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t                 state_q, state_d;
    logic [HDR_WIDTH-1:0]   n_q, n_d;
    logic [HDR_WIDTH-1:0]   idx_q, idx_d;
    logic [HDR_WIDTH-1:0]   n_full;
    logic                   asm_clear;
    logic                   asm_shift;
    logic [31:0]            asm_word;
    logic                   asm_full;

    // Kept outside the FSM process so wordFull does not feed back into it.
    assign asm_shift = (state_q == StCollect) && byteValid;

    word_assembler u_word_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (asm_clear),
        .shift    (asm_shift),
        .byteData (byteData),
        .word     (asm_word),
        .wordFull (asm_full)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            n_q     <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        idx_d        = idx_q;
        asm_clear    = 1'b0;
        byteReady    = 1'b0;
        memWrite     = 1'b0;
        memAddress   = 32'h0;
        memWriteData = 32'h0;
        cpuReset     = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        error        = 1'b0;
        n_full       = {n_q[15:8], byteData};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StHdrHi;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            StHdrHi: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (byteValid) begin
                    n_d     = {byteData, 8'h00};
                    state_d = StHdrLo;
                end
            end
            StHdrLo: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (byteValid) begin
                    n_d = n_full;
                    if (n_full == '0) begin
                        state_d = StDone;
                    end else if (32'(n_full) > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StCollect;
                    end
                end
            end
            StCollect: begin
                busy      = 1'b1;
                byteReady = 1'b1;
                if (asm_full) begin
                    state_d = StWrite;
                end
            end
            StWrite: begin
                busy         = 1'b1;
                memWrite     = 1'b1;
                // 32-bit add, wraps silently.
                memAddress   = BASE_ADDRESS + {14'd0, idx_q, 2'b00};
                memWriteData = asm_word;
                if (idx_q == n_q - 16'd1) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 16'd1;
                    state_d = StCollect;
                end
            end
            StDone: begin
                cpuReset = 1'b0;
                done     = 1'b1;
                if (start) begin
                    state_d   = StHdrHi;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            StError: begin
                error = 1'b1;
                if (start) begin
                    state_d   = StHdrHi;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs read as idle while reset is held, even before the first edge.
        if (!reset) begin
            byteReady    = 1'b0;
            memWrite     = 1'b0;
            memAddress   = 32'h0;
            memWriteData = 32'h0;
            cpuReset     = 1'b1;
            busy         = 1'b0;
            done         = 1'b0;
            error        = 1'b0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with default parameters (MAX_WORDS=256,
// BASE_ADDRESS=0).
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        byteValid = 1'b0;
    logic [7:0]  byteData = 8'h00;
    logic        byteReady;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        cpuReset;
    logic        busy;
    logic        done;
    logic        error;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byteValid    (byteValid),
        .byteData     (byteData),
        .byteReady    (byteReady),
        .memWrite     (memWrite),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .cpuReset     (cpuReset),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit tog    = 1'b0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (memWrite) begin
            wr_addr.push_back(memAddress);
            wr_data.push_back(memWriteData);
            wr_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input logic [31:0] addr,
                               input logic [31:0] data);
        if (idx < wr_addr.size()) begin
            check({tag, "_addr"}, wr_addr[idx], addr);
            check({tag, "_data"}, wr_data[idx], data);
        end else begin
            check({tag, "_missing"}, wr_addr.size(), idx + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns 1 time unit after the edge that accepted the byte.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        byteValid = 1'b1;
        byteData  = b;
        while (!byteReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!byteReady) check("byte_timeout", byteReady, 1);
        @(posedge clk);
        #1;
        byteValid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    // Same as send_byte, but byteValid alternates 1/0 every cycle.
    task automatic toggle_byte(input logic [7:0] b);
        int   guard = 0;
        logic acc = 1'b0;
        while (!acc && guard < 100) begin
            @(negedge clk);
            byteValid = tog;
            tog       = ~tog;
            byteData  = b;
            acc       = byteValid && byteReady;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) check("toggle_timeout", byteReady, 1);
        byteValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int t0;
        int t1;
        int rel_d;
        int rel_t;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", byteReady, 0);
        check("rst_mwr", memWrite, 0);
        check("rst_addr", memAddress, 0);
        check("rst_wdata", memWriteData, 0);
        check("rst_cpurst", cpuReset, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);

        // Idle ignores the byte stream
        @(negedge clk);
        reset     = 1'b1;
        byteValid = 1'b1;
        byteData  = 8'h55;
        repeat (3) tick();
        check("idle_ready", byteReady, 0);
        check("idle_busy", busy, 0);
        byteValid = 1'b0;

        // Two-word program
        base = wr_addr.size();
        pulse_start();
        check("hdr_busy", busy, 1);
        check("hdr_ready", byteReady, 1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'h2008_0005);
        check("w0_strobe", memWrite, 1);
        check("w0_addr", memAddress, 32'h0);
        check("w0_data", memWriteData, 32'h2008_0005);
        check("w0_ready", byteReady, 0);
        tick();
        check("w0_after_mwr", memWrite, 0);
        check("w0_after_busy", busy, 1);
        send_word(32'hAC08_0000);
        check("w1_strobe", memWrite, 1);
        check("w1_addr", memAddress, 32'h4);
        check("w1_data", memWriteData, 32'hAC08_0000);
        tick();
        check("two_done", done, 1);
        check("two_cpurst", cpuReset, 0);
        check("two_mwr", memWrite, 0);
        check("two_count", wr_addr.size(), base + 2);
        check_write("two_w0", base, 32'h0, 32'h2008_0005);
        check_write("two_w1", base + 1, 32'h4, 32'hAC08_0000);

        // Restart from DONE; a start while busy must not restart the header
        base = wr_addr.size();
        pulse_start();
        check("rs_cpurst", cpuReset, 1);
        check("rs_busy", busy, 1);
        check("rs_done", done, 0);
        send_byte(8'h00);
        pulse_start();
        send_byte(8'h01);
        send_word(32'hFFFF_FFFF);
        check("rs_strobe", memWrite, 1);
        check("rs_addr", memAddress, 32'h0);
        check("rs_data", memWriteData, 32'hFFFF_FFFF);
        tick();
        check("rs_done2", done, 1);
        check("rs_cpurst2", cpuReset, 0);
        check("rs_count", wr_addr.size(), base + 1);

        // Empty program
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h00);
        check("zero_done", done, 1);
        check("zero_cpurst", cpuReset, 0);
        check("zero_busy", busy, 0);
        repeat (2) tick();
        check("zero_count", wr_addr.size(), base);

        // Oversized header (257)
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        check("err_error", error, 1);
        check("err_cpurst", cpuReset, 1);
        check("err_ready", byteReady, 0);
        check("err_busy", busy, 0);
        repeat (2) tick();
        check("err_hold", error, 1);
        check("err_count", wr_addr.size(), base);
        pulse_start();
        check("err_rs_busy", busy, 1);
        check("err_rs_ready", byteReady, 1);
        check("err_rs_error", error, 0);
        // Exactly MAX_WORDS is accepted
        send_byte(8'h01);
        send_byte(8'h00);
        check("max_busy", busy, 1);
        check("max_error", error, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        @(negedge clk);
        reset = 1'b1;
        check("max_count", wr_addr.size(), base);

        // Same one-word load, continuous then with toggled byteValid
        base = wr_addr.size();
        pulse_start();
        t0 = cyc;
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'h1234_5678);
        tick();
        pulse_start();
        t1 = cyc;
        toggle_byte(8'h00);
        toggle_byte(8'h01);
        toggle_byte(8'h12);
        toggle_byte(8'h34);
        toggle_byte(8'h56);
        toggle_byte(8'h78);
        repeat (3) tick();
        check("tog_done", done, 1);
        check("tog_count", wr_addr.size(), base + 2);
        check_write("tog_direct", base, 32'h0, 32'h1234_5678);
        check_write("tog_toggled", base + 1, 32'h0, 32'h1234_5678);
        if (wr_cyc.size() >= base + 2) begin
            rel_d = wr_cyc[base] - t0;
            rel_t = wr_cyc[base + 1] - t1;
            check("tog_later", 32'(rel_t > rel_d), 1);
        end

        // Reset in the middle of a word
        base = wr_addr.size();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("mid_busy", busy, 0);
        check("mid_cpurst", cpuReset, 1);
        check("mid_ready", byteReady, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) tick();
        check("mid_nowrite", wr_addr.size(), base);
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_word(32'hDEAD_BEEF);
        check("mid_strobe", memWrite, 1);
        check("mid_addr", memAddress, 32'h0);
        check("mid_data", memWriteData, 32'hDEAD_BEEF);
        tick();
        check("mid_done", done, 1);
        check("mid_count", wr_addr.size(), base + 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 256, which is the largest accepted program length in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDRESS, default 32'h0, which is the byte address of the first written word.
REQ-003 Port list, one per line:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low; block is in reset while reset==0 at a rising clk edge.
- start  input  1  begin (or restart) a program load.
- byteValid  input  1  byteData holds a valid stream byte.
- byteData  input  8  program stream byte.
- byteReady  output  1  block accepts a byte this cycle.
- memWrite  output  1  instruction-memory write strobe.
- memAddress  output  32  instruction-memory byte address, word-aligned.
- memWriteData  output  32  instruction word to write.
- cpuReset  output  1  active-high hold-in-reset for the processor.
- busy  output  1  load in progress.
- done  output  1  load completed successfully.
- error  output  1  header word count exceeded MAX_WORDS.

Function
REQ-004 A byte SHALL be accepted only at a rising edge where byteValid==1 and byteReady==1.
REQ-005 The stream format SHALL be a 16-bit word count N (high byte first), followed by 4*N bytes forming N words, most significant byte first.
REQ-006 The FSM SHALL have states IDLE, HDR_HI, HDR_LO, COLLECT, WRITE, DONE and ERROR.
REQ-007 IDLE SHALL go to HDR_HI on start==1; all other inputs SHALL be ignored in IDLE.
REQ-008 HDR_HI SHALL go to HDR_LO on an accepted byte.
REQ-009 HDR_LO SHALL leave on an accepted byte as follows: N==0 goes to DONE, N>MAX_WORDS goes to ERROR, and any other N goes to COLLECT.
REQ-010 COLLECT SHALL shift bytes into a 32-bit assembly register and, on the 4th accepted byte of a word, go to WRITE.
REQ-011 In WRITE, memWrite SHALL be 1 for exactly one cycle, with memAddress = BASE_ADDRESS + 4*wordIndex and memWriteData = the assembled word.
REQ-012 WRITE SHALL then go to DONE if wordIndex==N-1, and to COLLECT otherwise with wordIndex incremented.
REQ-013 Write latency SHALL be exactly 1 cycle: memWrite is asserted in the cycle following acceptance of the 4th byte.
REQ-014 byteReady SHALL be 1 only in HDR_HI, HDR_LO and COLLECT; it SHALL be 0 in WRITE, so no byte is accepted while writing.
REQ-015 memWrite SHALL be 0 in every state except WRITE; memAddress and memWriteData are don't-care when memWrite==0 but SHALL be driven to 0.
REQ-016 cpuReset SHALL be 0 only in DONE; it SHALL be 1 in all other states, including IDLE and ERROR.
REQ-017 busy SHALL be 1 in HDR_HI, HDR_LO, COLLECT and WRITE; done SHALL be 1 only in DONE; error SHALL be 1 only in ERROR.
REQ-018 start==1 in DONE or ERROR SHALL go to HDR_HI, clear the word index and assembly byte count, and reassert cpuReset in the next cycle.
REQ-019 start SHALL be ignored while busy==1.
REQ-020 byteValid with byteReady==0 SHALL not be consumed; the source holds the byte.
REQ-021 Address arithmetic SHALL be 32-bit unsigned and wrap modulo 2^32 without flagging.
REQ-022 The word counter SHALL be 16 bits wide; the byte-in-word counter SHALL be 2 bits wide.

Reset
REQ-023 While reset==0 at a rising clk edge, the block SHALL go to IDLE and clear N, wordIndex, the byte count and the assembly register.
REQ-024 In reset, outputs SHALL be byteReady=0, memWrite=0, memAddress=0, memWriteData=0, cpuReset=1, busy=0, done=0, error=0.
REQ-025 A reset during a load SHALL discard the partial word, issue no further memWrite, and keep cpuReset at 1.

Structure
REQ-026 Shared package loader_pkg SHALL hold the state enum typedef, the DEFAULT_MAX_WORDS constant and the header width constant (16).
REQ-027 Sub-module word_assembler SHALL hold the 8-to-32 big-endian shift register and the 2-bit byte counter, and SHALL assert wordFull on the 4th byte.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Stream 00 02 | 20 08 00 05 | AC 08 00 00 -> two memWrite pulses: addr 0x0 data 0x20080005, then addr 0x4 data 0xAC080000; done=1 and cpuReset=0 the cycle after the second write.
- Header 00 00 -> DONE right after HDR_LO, no memWrite, cpuReset=0.
- Header 01 01 (257) with MAX_WORDS=256 -> error=1, cpuReset=1, byteReady=0, no memWrite; a later start returns to HDR_HI.
- byteValid toggled 1/0 every cycle during N=1 -> identical write (same address and data), later in time; no byte lost or duplicated.
- reset=0 after 2 of 4 data bytes -> IDLE, no memWrite; a new load with N=1 writes addr BASE_ADDRESS with the new word only.
- start in DONE, then reload with N=1, data 0xFFFFFFFF -> cpuReset=1 the next cycle; write at addr 0x0; done again.
